// File: rtl/instr_reg_scheduler_pkg.sv
// instr_reg_scheduler_pkg: shared instruction-register types and depth constants
package instr_reg_scheduler_pkg;
  localparam int NUM_ENTRIES = 32;
  localparam int CW = $clog2(NUM_ENTRIES) + 1;
  typedef enum logic [3:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;
  typedef logic signed [31:0] operand_t;
  typedef logic [$clog2(NUM_ENTRIES)-1:0] address_t;
  typedef logic [CW-1:0] count_t;
  typedef struct packed {
    opcode_t  opcode;
    operand_t op_a;
    operand_t op_b;
  } instr_t;
  function automatic address_t next_addr(address_t a);
    return a + 1'b1;
  endfunction
endpackage

// File: rtl/instr_reg_scheduler_if.sv
// instr_reg_scheduler_if: requester, register-write and consumer signals of the scheduler
interface instr_reg_scheduler_if #(parameter int NUM_REQ = 2);
  import instr_reg_scheduler_pkg::*;
  logic [NUM_REQ-1:0] req, gnt;
  opcode_t req_opcode [NUM_REQ];
  operand_t req_operand_a [NUM_REQ];
  operand_t req_operand_b [NUM_REQ];
  logic load_en, rd_req, rd_valid, full, empty;
  opcode_t opcode;
  operand_t operand_a, operand_b;
  address_t write_pointer, read_pointer;
  count_t count;
  modport master (
    output req, req_opcode, req_operand_a, req_operand_b, rd_req,
    input gnt, load_en, opcode, operand_a, operand_b, write_pointer,
    input read_pointer, rd_valid, count, full, empty
  );
  modport slave (
    input req, req_opcode, req_operand_a, req_operand_b, rd_req,
    output gnt, load_en, opcode, operand_a, operand_b, write_pointer,
    output read_pointer, rd_valid, count, full, empty
  );
endinterface

// File: rtl/instr_reg_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin one-hot arbiter; priority moves past each granted index
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en_i,
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gidx_o
);
  logic [IW-1:0] ptr_q, ptr_d, cand;
  logic any, fire;
  always_comb begin
    cand = '0;
    gidx_o = ptr_q;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(ptr_q) + i) % N);
      if (!any && req_i[cand]) begin
        gidx_o = cand;
        any = 1'b1;
      end
    end
  end
  assign fire = any && en_i && !reset;
  assign gnt_o = fire ? N'(1) << gidx_o : '0;
  assign ptr_d = fire ? IW'((int'(gidx_o) + 1) % N) : ptr_q;
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end
endmodule

// File: rtl/instr_reg_scheduler.sv
// instr_reg_scheduler: arbitrates instruction-register writes and sequences FIFO reads
module instr_reg_scheduler
  import instr_reg_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input logic clk,
  input logic reset,
  instr_reg_scheduler_if.slave bus
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  logic [IW-1:0] gidx;
  logic grant, rd_acc;
  logic load_en_q, load_en_d, rd_valid_q, rd_valid_d;
  instr_t wr_q, wr_d, req_w;
  address_t wp_q, wp_d, rp_q, rp_d, wslot_q, wslot_d, rslot_q, rslot_d;
  count_t count_q, count_d;
  logic [CW:0] occ;
  // an in-flight write already owns a slot, so it counts toward full
  assign occ = {1'b0, count_q} + (CW+1)'(load_en_q);
  assign bus.full = occ == (CW+1)'(NUM_ENTRIES);
  assign bus.empty = count_q == '0;
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk    (clk),
    .reset  (reset),
    .en_i   (!bus.full),
    .req_i  (bus.req),
    .gnt_o  (bus.gnt),
    .gidx_o (gidx)
  );
  assign grant = |bus.gnt;
  assign rd_acc = bus.rd_req && !bus.empty;
  assign req_w = '{opcode: bus.req_opcode[gidx], op_a: bus.req_operand_a[gidx],
                   op_b: bus.req_operand_b[gidx]};
  always_comb begin
    load_en_d = grant;
    wr_d = grant ? req_w : wr_q;
    wp_d = grant ? wslot_q : wp_q;
    wslot_d = grant ? next_addr(wslot_q) : wslot_q;
    rd_valid_d = rd_acc;
    rp_d = rd_acc ? rslot_q : rp_q;
    rslot_d = rd_acc ? next_addr(rslot_q) : rslot_q;
    count_d = count_q + count_t'(load_en_q) - count_t'(rd_acc);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      load_en_q <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      wslot_q <= '0;
      rslot_q <= '0;
      count_q <= '0;
    end else begin
      load_en_q <= load_en_d;
      rd_valid_q <= rd_valid_d;
      wr_q <= wr_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      wslot_q <= wslot_d;
      rslot_q <= rslot_d;
      count_q <= count_d;
    end
  end
  assign bus.load_en = load_en_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.opcode = wr_q.opcode;
  assign bus.operand_a = wr_q.op_a;
  assign bus.operand_b = wr_q.op_b;
  assign bus.write_pointer = wp_q;
  assign bus.read_pointer = rp_q;
  assign bus.count = count_q;
endmodule

// File: tb/tb_instr_reg_scheduler.sv
// tb_instr_reg_scheduler: directed scenarios plus random traffic against a queue-based model
module tb_instr_reg_scheduler;
  import instr_reg_scheduler_pkg::*;
  localparam int NR = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  instr_reg_scheduler_if #(.NUM_REQ(NR)) bus ();
  instr_reg_scheduler #(.NUM_REQ(NR)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  // model: q holds every granted, not-yet-read entry in order
  instr_t q[$];
  instr_t mem [NUM_ENTRIES];
  instr_t e_word, e_rdata;
  bit e_load, e_rvalid;
  int e_wp, e_rp, prio, wslot, rslot;

  function automatic int pick();
    if (reset || q.size() == NUM_ENTRIES) return -1;
    for (int i = 0; i < NR; i++) if (bus.req[(prio + i) % NR]) return (prio + i) % NR;
    return -1;
  endfunction

  function automatic int e_count();
    return q.size() - (e_load ? 1 : 0);
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(string name, instr_t act, instr_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    e_word = '0;
    e_rdata = '0;
    forever begin
      int g;
      bit acc;
      @(posedge clk);
      g = pick();
      acc = bus.rd_req && e_count() > 0;
      if (reset) begin
        q.delete();
        e_load = 0; e_rvalid = 0; e_wp = 0; e_rp = 0; e_word = '0;
        prio = 0; wslot = 0; rslot = 0;
      end else begin
        e_rvalid = acc;
        if (acc) begin
          e_rp = rslot;
          e_rdata = q.pop_front();
          rslot = (rslot + 1) % NUM_ENTRIES;
        end
        e_load = g >= 0;
        if (g >= 0) begin
          e_word = {bus.req_opcode[g], bus.req_operand_a[g], bus.req_operand_b[g]};
          q.push_back(e_word);
          e_wp = wslot;
          wslot = (wslot + 1) % NUM_ENTRIES;
          prio = (g + 1) % NR;
        end
      end
    end
  end

  initial forever begin
    int g;
    instr_t w;
    @(negedge clk);
    g = pick();
    w = {bus.opcode, bus.operand_a, bus.operand_b};
    chk("gnt", int'(bus.gnt), g < 0 ? 0 : 1 << g);
    chk("load_en", int'(bus.load_en), int'(e_load));
    chk("rd_valid", int'(bus.rd_valid), int'(e_rvalid));
    chk("count", int'(bus.count), e_count());
    chk("full", int'(bus.full), int'(q.size() == NUM_ENTRIES));
    chk("empty", int'(bus.empty), int'(e_count() == 0));
    chk("write_pointer", int'(bus.write_pointer), e_wp);
    chk("read_pointer", int'(bus.read_pointer), e_rp);
    chkw("write_data", w, e_word);
    if (bus.load_en) mem[bus.write_pointer] = w;
    if (e_rvalid) chkw("read_data", mem[bus.read_pointer], e_rdata);
  end

  task automatic set_req(int r, opcode_t op, int a, int b);
    bus.req_opcode[r] = op;
    bus.req_operand_a[r] = a;
    bus.req_operand_b[r] = b;
  endtask

  initial begin
    bus.req = '0;
    bus.rd_req = 1'b0;
    for (int r = 0; r < NR; r++) set_req(r, ZERO, 0, 0);
    repeat (3) tick();
    reset = 1'b0;
    // single write then read
    bus.req = 2'b01;
    set_req(0, ADD, 5, 3);
    #1 chk("lit_gnt0", int'(bus.gnt), 1);
    tick();
    bus.req = '0;
    #1;
    chk("lit_load_en", int'(bus.load_en), 1);
    chk("lit_wp0", int'(bus.write_pointer), 0);
    chkw("lit_wdata", {bus.opcode, bus.operand_a, bus.operand_b}, {ADD, 32'sd5, 32'sd3});
    chk("lit_count0", int'(bus.count), 0);
    tick();
    #1 chk("lit_count1", int'(bus.count), 1);
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    #1;
    chk("lit_rd_valid", int'(bus.rd_valid), 1);
    chk("lit_rp0", int'(bus.read_pointer), 0);
    chkw("lit_rdata", mem[bus.read_pointer], {ADD, 32'sd5, 32'sd3});
    // round robin from a fresh reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req = 2'b11;
    set_req(0, SUB, 100, 1);
    set_req(1, MULT, 200, 2);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("lit_rr_gnt", int'(bus.gnt), k % 2 == 0 ? 1 : 2);
      tick();
      #1;
      chk("lit_rr_wp", int'(bus.write_pointer), k);
      chk("lit_rr_a", int'(bus.operand_a), k % 2 == 0 ? 100 : 200);
    end
    bus.req = '0;
    // fill to full
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req = 2'b01;
    for (int k = 0; k < 32; k++) begin
      set_req(0, PASSA, k, -k);
      tick();
    end
    #1;
    chk("lit_full_pending", int'(bus.full), 1);
    chk("lit_full_gnt", int'(bus.gnt), 0);
    tick();
    #1;
    chk("lit_full_count", int'(bus.count), 32);
    chk("lit_full_gnt33", int'(bus.gnt), 0);
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    #1;
    chk("lit_after_read_count", int'(bus.count), 31);
    chk("lit_after_read_gnt", int'(bus.gnt), 1);
    tick();
    #1;
    chk("lit_wrap_wp", int'(bus.write_pointer), 0);
    chk("lit_refull_gnt", int'(bus.gnt), 0);
    bus.req = '0;
    // empty reads and minimum write-to-read latency
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.rd_req = 1'b1;
    tick();
    #1;
    chk("lit_empty_rv", int'(bus.rd_valid), 0);
    chk("lit_empty_count", int'(bus.count), 0);
    bus.req = 2'b01;
    set_req(0, DIV, 77, 7);
    tick();
    bus.req = '0;
    #1 chk("lit_t1_rv", int'(bus.rd_valid), 0);
    tick();
    #1 chk("lit_t2_rv", int'(bus.rd_valid), 0);
    tick();
    #1 chk("lit_t3_rv", int'(bus.rd_valid), 1);
    bus.rd_req = 1'b0;
    // concurrent streaming with wrap
    bus.req = 2'b10;
    set_req(1, MOD, 900, 9);
    tick();
    set_req(1, MOD, 901, 9);
    tick();
    bus.req = '0;
    repeat (2) tick();
    bus.req = 2'b10;
    tick();
    bus.rd_req = 1'b1;
    for (int k = 0; k < 40; k++) begin
      set_req(1, opcode_t'(k % 8), 1000 + k, k);
      tick();
      #1 chk("lit_stream_count", int'(bus.count), 2);
    end
    bus.req = '0;
    repeat (4) tick();
    bus.rd_req = 1'b0;
    // random traffic with a mid-run reset
    for (int c = 0; c < 1500; c++) begin
      int rdp;
      rdp = (c / 300) % 3 == 0 ? 20 : ((c / 300) % 3 == 1 ? 90 : 50);
      if (c == 700) begin
        reset = 1'b1;
        bus.req = 2'b11;
        #1 chk("lit_rst_gnt", int'(bus.gnt), 0);
        tick();
        #1 chk("lit_rst_gnt2", int'(bus.gnt), 0);
        tick();
        reset = 1'b0;
        bus.req = '0;
        #1;
        chk("lit_rst_load_en", int'(bus.load_en), 0);
        chk("lit_rst_rd_valid", int'(bus.rd_valid), 0);
        chk("lit_rst_count", int'(bus.count), 0);
        chk("lit_rst_empty", int'(bus.empty), 1);
        chk("lit_rst_wp", int'(bus.write_pointer), 0);
        chk("lit_rst_rp", int'(bus.read_pointer), 0);
      end
      bus.req = NR'($urandom_range(0, 3));
      for (int r = 0; r < NR; r++)
        if (!bus.gnt[r] || $urandom_range(0, 1) == 1)
          set_req(r, opcode_t'($urandom_range(0, 7)), int'($urandom), int'($urandom));
      bus.rd_req = $urandom_range(0, 99) < rdp;
      tick();
    end
    bus.req = '0;
    bus.rd_req = 1'b0;
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
